// File: rtl/sigma_delta_adc_decim.sv
// 3rd-order CIC decimator turning a 1-bit sigma-delta bitstream into signed 18-bit samples.
// Optional build macro SD_ADC_DC_BLOCK_EN adds a one-pole DC-blocking high-pass after saturation.
module sigma_delta_adc_decim #(
  parameter  int DECIM_LOG2 = 6,
  localparam int ACC_W      = 3*DECIM_LOG2 + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  output logic signed [17:0] smpl,
  output logic               smpl_rdy
);

  localparam int GAIN_LOG2 = 3*DECIM_LOG2;
  localparam int SHR       = (GAIN_LOG2 > 16) ? (GAIN_LOG2 - 16) : 0;
  localparam int SHL       = (GAIN_LOG2 < 16) ? (16 - GAIN_LOG2) : 0;
  localparam int SAT_W     = ACC_W + 16;

  localparam logic signed [SAT_W-1:0]  POS_FS  = SAT_W'(32'sd65536);
  localparam logic signed [SAT_W-1:0]  NEG_FS  = SAT_W'(-32'sd65536);
  localparam logic [DECIM_LOG2-1:0]    CNT_MAX = {DECIM_LOG2{1'b1}};
  localparam logic [DECIM_LOG2-1:0]    CNT_ONE = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_C1   = 3'd1;
  localparam logic [2:0] ST_C2   = 3'd2;
  localparam logic [2:0] ST_C3   = 3'd3;
  localparam logic [2:0] ST_OUT  = 3'd4;
`ifdef SD_ADC_DC_BLOCK_EN
  localparam logic [2:0] ST_DCB  = 3'd5;
`endif

  function automatic logic signed [17:0] sat18(input logic signed [SAT_W-1:0] v);
    logic signed [17:0] r;
    if (v > POS_FS) begin
      r = 18'sh10000;
    end else if (v < NEG_FS) begin
      r = 18'sh30000;
    end else begin
      r = v[17:0];
    end
    return r;
  endfunction

  logic [DECIM_LOG2-1:0]   cnt_r;
  logic [ACC_W-1:0]        i1_r, i2_r, i3_r;
  logic [ACC_W-1:0]        cap_r;
  logic [ACC_W-1:0]        d1_r, d2_r, d3_r;
  logic [ACC_W-1:0]        c1_r, c2_r, c3_r;
  logic [2:0]              state_r;
  logic [1:0]              warm_r;
  logic signed [17:0]      smpl_r;
  logic                    smpl_rdy_r;
  logic [ACC_W-1:0]        step_s;
  logic signed [SAT_W-1:0] ext_s;
  logic signed [SAT_W-1:0] norm_s;
  logic signed [17:0]      sat_s;

  // Bitstream to +/-1 step, and normalisation so CIC full scale lands on +/-2^16.
  always_comb begin
    step_s = {{(ACC_W-1){~din}}, 1'b1};
    ext_s  = SAT_W'($signed(c3_r));
    if (GAIN_LOG2 >= 16) begin
      norm_s = ext_s >>> SHR;
    end else begin
      norm_s = ext_s <<< SHL;
    end
    sat_s = sat18(norm_s);
  end

`ifdef SD_ADC_DC_BLOCK_EN
  logic signed [17:0] x_r, x_prev_r, y_prev_r;
  logic signed [19:0] y_s;
  logic signed [17:0] y_sat_s;

  // One-pole high-pass: y = x - x_prev + y_prev - y_prev/1024, then clamped.
  always_comb begin
    y_s     = 20'(x_r) - 20'(x_prev_r) + 20'(y_prev_r) - 20'(y_prev_r >>> 10);
    y_sat_s = sat18(SAT_W'(y_s));
  end
`endif

  // Integrators, decimation counter and the comb/output sequencer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r      <= '0;
      i1_r       <= '0;
      i2_r       <= '0;
      i3_r       <= '0;
      cap_r      <= '0;
      d1_r       <= '0;
      d2_r       <= '0;
      d3_r       <= '0;
      c1_r       <= '0;
      c2_r       <= '0;
      c3_r       <= '0;
      state_r    <= ST_IDLE;
      warm_r     <= 2'd0;
      smpl_r     <= 18'sd0;
      smpl_rdy_r <= 1'b0;
`ifdef SD_ADC_DC_BLOCK_EN
      x_r        <= 18'sd0;
      x_prev_r   <= 18'sd0;
      y_prev_r   <= 18'sd0;
`endif
    end else begin
      i1_r       <= i1_r + step_s;
      i2_r       <= i2_r + i1_r;
      i3_r       <= i3_r + i2_r;
      cnt_r      <= cnt_r + CNT_ONE;
      smpl_rdy_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cnt_r == CNT_MAX) begin
            cap_r   <= i3_r;
            state_r <= ST_C1;
          end
        end
        ST_C1: begin
          c1_r    <= cap_r - d1_r;
          d1_r    <= cap_r;
          state_r <= ST_C2;
        end
        ST_C2: begin
          c2_r    <= c1_r - d2_r;
          d2_r    <= c1_r;
          state_r <= ST_C3;
        end
        ST_C3: begin
          c3_r    <= c2_r - d3_r;
          d3_r    <= c2_r;
          state_r <= ST_OUT;
        end
        ST_OUT: begin
`ifdef SD_ADC_DC_BLOCK_EN
          x_r     <= sat_s;
          state_r <= ST_DCB;
`else
          smpl_r  <= sat_s;
          state_r <= ST_IDLE;
          // The first three periods only settle the comb delays.
          if (warm_r == 2'd3) begin
            smpl_rdy_r <= 1'b1;
          end else begin
            warm_r <= warm_r + 2'd1;
          end
`endif
        end
`ifdef SD_ADC_DC_BLOCK_EN
        ST_DCB: begin
          smpl_r   <= y_sat_s;
          x_prev_r <= x_r;
          y_prev_r <= y_sat_s;
          state_r  <= ST_IDLE;
          if (warm_r == 2'd3) begin
            smpl_rdy_r <= 1'b1;
          end else begin
            warm_r <= warm_r + 2'd1;
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign smpl     = smpl_r;
  assign smpl_rdy = smpl_rdy_r;

endmodule

// File: doc/sigma_delta_adc_decim.md
Name: sigma_delta_adc_decim

Overview:
- Receive-side counterpart of the sigma-delta DAC path.
- Takes the 1-bit modulator bitstream from an external comparator/flip-flop at clk rate.
- Runs it through a 3rd-order CIC decimator and delivers signed 18-bit samples with a one-cycle smpl_rdy strobe.
- Output scaling matches the DAC input range: full scale is ±18'h10000, so a looped-back stream reproduces the DAC sample.

Parameters:
- DECIM_LOG2, 6: log2 of the decimation ratio R (R = 2^DECIM_LOG2). Legal range 3..8.
- ACC_W, 3*DECIM_LOG2+2: CIC register width. Derived; do not override.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
- din  input  1  modulator bitstream; 1 means +1, 0 means -1
- smpl  output  18  signed decimated sample, two's complement
- smpl_rdy  output  1  one-cycle pulse; smpl is valid in the same cycle

Behaviour:
- Reset (reset==0 at a rising edge):
  - clears all integrators, comb delays, decim counter, warm-up counter, FSM (to IDLE), smpl and smpl_rdy.
  - Applies mid-operation too: any in-flight comb computation is discarded; no smpl_rdy in the cycle after reset.
- Integrators:
  - Three cascaded ACC_W-bit integrators update every clk. i1 += (din ? +1 : -1); i2 += i1; i3 += i2 (registered values).
  - Modular wrap-around is intended. No saturation is allowed inside the CIC.
- Decimation counter:
  - DECIM_LOG2-bit counter increments every clk and wraps R-1 -> 0.
  - At the edge where cnt==R-1, i3 (its pre-update register value) is captured into cap and the FSM leaves IDLE.
- FSM states:
  - IDLE -> C1 on capture.
  - C1: c1 = cap - d1; d1 <= cap.
  - C2: c2 = c1 - d2; d2 <= c1.
  - C3: c3 = c2 - d3; d3 <= c2.
  - OUT: smpl <= sat18(c3 >>> 2); smpl_rdy = 1 for exactly this cycle if warm-up is done; then back to IDLE.
  - Latency: smpl_rdy rises 4 clk after the capture edge.
  - R >= 8 guarantees the FSM is back in IDLE before the next capture. A capture can never coincide with a busy FSM.
- Gain and width:
  - CIC gain is R^3 = 2^(3*DECIM_LOG2). The c3 range is ±2^(3*DECIM_LOG2).
  - The result is normalised by an arithmetic right shift of (3*DECIM_LOG2 - 16), so ±2^16 maps to ±18'h10000. For DECIM_LOG2=6 the shift is 2.
  - For DECIM_LOG2 < 6 the shift becomes a left shift by (16 - 3*DECIM_LOG2).
  - sat18 clamps to [18'h30000, 18'h10000], the same range the DAC accepts.
- Warm-up:
  - The first 3 completed decimation periods after reset produce no smpl_rdy (CIC settling). smpl is still updated internally.
  - The 4th OUT and every later OUT pulse smpl_rdy.
- smpl holds its value between strobes.

Optional Feature:
- SD_ADC_DC_BLOCK_EN
- Defined: adds a one-pole DC-blocking high-pass after sat18.
  - y = x - x_prev + y_prev - (y_prev >>> 10), computed in 20 bits and saturated to 18 bits.
  - Adds one extra FSM state (DCB) between OUT-compute and the strobe, so latency becomes 5 clk.
  - x_prev and y_prev clear on reset.
- Undefined: no DCB state, latency 4 clk, smpl = sat18 output directly.

Test Plan:
- Constant din=1 for 10 periods (R=64) -> first smpl_rdy at the end of period 4, 4 clk after the capture edge; smpl = 18'h10000 on every strobe.
- Constant din=0 -> smpl = 18'h30000 (-65536) on every post-warm-up strobe.
- Repeating 1,1,1,0 -> smpl = 18'h08000 (+0.5 FS) steady. Alternating 1,0 -> smpl = 18'h00000.
- Strobe spacing: any stream -> smpl_rdy exactly 1 clk wide, exactly R=64 clk apart, none during the first 3 periods.
- Reset mid-operation: assert reset while in C2 -> smpl=0, smpl_rdy=0. The next strobe is 4 full periods after reset release, with no stale value.
- With SD_ADC_DC_BLOCK_EN, constant din=1 -> first strobe ≈ 18'h10000, then monotonic decay toward 0 (below 18'h01000 within ~3000 strobes); latency 5 clk.
